// File: rtl/sv_page_walker.sv
// sv_page_walker: instruction-side address translator between fetch and the Sysbus.
// A small fully-associative TLB answers hits in one cycle; misses run a multi-level
// Sv39/Sv48-style page-table walk, one line burst per level, one translation in flight.
module sv_page_walker #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int LEVELS         = 4,
  parameter int PA_WIDTH       = 56,
  parameter int LINE_BEATS     = 8,
  parameter int PTESIZE        = 8,
  parameter int TLB_ENTRIES    = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      translate_en,
  input  logic [43:0]               ptbr_ppn,
  input  logic                      tlb_flush,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [63:0]               req_vaddr,
  output logic                      resp_valid,
  output logic [PA_WIDTH-1:0]       resp_paddr,
  output logic                      resp_fault,
  output logic                      bus_reqcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_req,
  output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  output logic                      bus_respack,
  input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  localparam int VA_WIDTH = 12 + 9 * LEVELS;
  localparam int VPN_W    = 9 * LEVELS;
  localparam int PPN_W    = 44;
  localparam int LVL_W    = (LEVELS > 1) ? $clog2(LEVELS) : 1;
  localparam int OFF_W    = $clog2(LINE_BEATS * 8);
  localparam int BEAT_W   = $clog2(LINE_BEATS);
  localparam int PTR_W    = (TLB_ENTRIES > 1) ? $clog2(TLB_ENTRIES) : 1;

  localparam logic       SYSBUS_READ   = 1'b1;
  localparam logic [3:0] SYSBUS_MEMORY = 4'b0001;
  localparam logic [BUS_TAG_WIDTH-1:0] READ_TAG =
    BUS_TAG_WIDTH'({SYSBUS_READ, SYSBUS_MEMORY, 8'h00});
  localparam logic [PA_WIDTH-1:0] OFF_MASK = PA_WIDTH'((64'd1 << OFF_W) - 64'd1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_BEATS,
    S_CHECK,
    S_RESP
  } state_t;

  state_t                state;
  logic [VA_WIDTH-1:0]   vaddr_q;
  logic [PA_WIDTH-1:0]   a_q;
  logic [LVL_W-1:0]      lvl_q;
  logic [BEAT_W:0]       beat_cnt;
  logic [BUS_DATA_WIDTH-1:0] pte_q;
  logic                  flushed_q;
  logic [PTR_W-1:0]      repl_ptr;

  logic [TLB_ENTRIES-1:0] tlb_valid;
  logic [VPN_W-1:0]       tlb_vpn [TLB_ENTRIES];
  logic [PPN_W-1:0]       tlb_ppn [TLB_ENTRIES];
  logic [LVL_W-1:0]       tlb_lvl [TLB_ENTRIES];

  // Address of the PTE for level lvl inside the table at base.
  function automatic logic [PA_WIDTH-1:0] pte_addr_f(input logic [PA_WIDTH-1:0] base,
                                                     input logic [LVL_W-1:0] lvl,
                                                     input logic [VA_WIDTH-1:0] va);
    logic [8:0] idx;
    idx = va[12 + 9 * int'(lvl) +: 9];
    return base + PA_WIDTH'(idx) * PA_WIDTH'(PTESIZE);
  endfunction

  // Line-aligned bus address for a PTE address.
  function automatic logic [BUS_DATA_WIDTH-1:0] line_f(input logic [PA_WIDTH-1:0] pa);
    return BUS_DATA_WIDTH'(pa & ~OFF_MASK);
  endfunction

  // Leaf PPN with the page-offset bits (12 + 9*lvl of them) taken from the VA.
  function automatic logic [PA_WIDTH-1:0] paddr_f(input logic [PPN_W-1:0] ppn,
                                                  input logic [LVL_W-1:0] lvl,
                                                  input logic [VA_WIDTH-1:0] va);
    logic [63:0] keep;
    keep = (64'd1 << (12 + 9 * int'(lvl))) - 64'd1;
    return PA_WIDTH'(((64'(ppn) << 12) & ~keep) | (64'(va) & keep));
  endfunction

  // VPN bits that take part in a match for an entry mapped at level lvl.
  function automatic logic [VPN_W-1:0] vpn_mask_f(input logic [LVL_W-1:0] lvl);
    return ~VPN_W'((64'd1 << (9 * int'(lvl))) - 64'd1);
  endfunction

  // PTE decode for the CHECK state.
  logic [PPN_W-1:0] pte_ppn;
  logic pte_v, pte_r, pte_w, pte_x;
  logic chk_bad, chk_nonleaf, chk_misaligned, chk_leaf_ok, fill_en;

  assign pte_ppn        = pte_q[53:10];
  assign pte_v          = pte_q[0];
  assign pte_r          = pte_q[1];
  assign pte_w          = pte_q[2];
  assign pte_x          = pte_q[3];
  assign chk_bad        = !pte_v || (pte_w && !pte_r);
  assign chk_nonleaf    = !pte_r && !pte_x;
  assign chk_misaligned = (pte_ppn & PPN_W'((64'd1 << (9 * int'(lvl_q))) - 64'd1)) != '0;
  assign chk_leaf_ok    = !chk_bad && !chk_nonleaf && pte_x && !chk_misaligned;
  // A flush anywhere in the walk, including this very cycle, suppresses the fill.
  assign fill_en        = (state == S_CHECK) && chk_leaf_ok && !flushed_q && !tlb_flush;

  // Beat holding the wanted PTE in the current line.
  logic [PA_WIDTH-1:0] cur_pte_addr;
  logic [BEAT_W-1:0]   beat_sel;
  assign cur_pte_addr = pte_addr_f(a_q, lvl_q, vaddr_q);
  assign beat_sel     = cur_pte_addr[OFF_W-1:3];

  // Beats are always consumed; outside BEATS they are simply dropped so the bus drains.
  assign bus_respack = bus_respcyc;
  assign bus_reqtag  = bus_reqcyc ? READ_TAG : '0;

  logic [VPN_W-1:0] req_vpn;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  assign req_vpn = req_vaddr[VA_WIDTH-1:12];

  // Fully-associative TLB lookup on the incoming request address.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < TLB_ENTRIES; i++) begin
      if (!hit && tlb_valid[i] &&
          (((tlb_vpn[i] ^ req_vpn) & vpn_mask_f(tlb_lvl[i])) == '0)) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  // TLB payload written on a successful walk.
  always_ff @(posedge clk) begin
    // NOTE: the payload array has no reset; an entry is never read while its valid bit is clear.
    if (fill_en) begin
      tlb_vpn[repl_ptr] <= vaddr_q[VA_WIDTH-1:12];
      tlb_ppn[repl_ptr] <= pte_ppn;
      tlb_lvl[repl_ptr] <= lvl_q;
    end
  end

  // Control FSM with registered handshake, bus and response outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register sees pre-edge values.
    if (reset) begin
      state      <= S_IDLE;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_paddr <= '0;
      resp_fault <= 1'b0;
      bus_reqcyc <= 1'b0;
      bus_req    <= '0;
      vaddr_q    <= '0;
      a_q        <= '0;
      lvl_q      <= '0;
      beat_cnt   <= '0;
      pte_q      <= '0;
      flushed_q  <= 1'b0;
      repl_ptr   <= '0;
      tlb_valid  <= '0;
    end else begin
      resp_valid <= 1'b0;
      if (tlb_flush) begin
        tlb_valid <= '0;
        if (state != S_IDLE) flushed_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            vaddr_q   <= req_vaddr[VA_WIDTH-1:0];
            flushed_q <= 1'b0;
            if (!translate_en) begin
              resp_valid <= 1'b1;
              resp_paddr <= req_vaddr[PA_WIDTH-1:0];
              resp_fault <= 1'b0;
              state      <= S_RESP;
            end else if (hit && !tlb_flush) begin
              resp_valid <= 1'b1;
              resp_paddr <= paddr_f(tlb_ppn[hit_idx], tlb_lvl[hit_idx], req_vaddr[VA_WIDTH-1:0]);
              resp_fault <= 1'b0;
              state      <= S_RESP;
            end else begin
              lvl_q      <= LVL_W'(LEVELS - 1);
              a_q        <= PA_WIDTH'({ptbr_ppn, 12'h000});
              bus_reqcyc <= 1'b1;
              bus_req    <= line_f(pte_addr_f(PA_WIDTH'({ptbr_ppn, 12'h000}),
                                              LVL_W'(LEVELS - 1), req_vaddr[VA_WIDTH-1:0]));
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus_reqack) begin
            bus_reqcyc <= 1'b0;
            beat_cnt   <= '0;
            state      <= S_BEATS;
          end
        end
        S_BEATS: begin
          if (bus_respcyc) begin
            if (beat_cnt[BEAT_W-1:0] == beat_sel) pte_q <= bus_resp;
            beat_cnt <= beat_cnt + (BEAT_W + 1)'(1);
            if (beat_cnt == (BEAT_W + 1)'(LINE_BEATS - 1)) state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (!chk_bad && chk_nonleaf && (lvl_q != '0)) begin
            a_q        <= PA_WIDTH'({pte_ppn, 12'h000});
            lvl_q      <= lvl_q - LVL_W'(1);
            bus_reqcyc <= 1'b1;
            bus_req    <= line_f(pte_addr_f(PA_WIDTH'({pte_ppn, 12'h000}),
                                            lvl_q - LVL_W'(1), vaddr_q));
            state      <= S_REQ;
          end else if (chk_leaf_ok) begin
            resp_valid <= 1'b1;
            resp_paddr <= paddr_f(pte_ppn, lvl_q, vaddr_q);
            resp_fault <= 1'b0;
            state      <= S_RESP;
            if (fill_en) begin
              tlb_valid[repl_ptr] <= 1'b1;
              repl_ptr <= (repl_ptr == PTR_W'(TLB_ENTRIES - 1)) ? '0 : repl_ptr + PTR_W'(1);
            end
          end else begin
            resp_valid <= 1'b1;
            resp_paddr <= '0;
            resp_fault <= 1'b1;
            state      <= S_RESP;
          end
        end
        S_RESP: begin
          req_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Bits that are deliberately ignored: response tag, PTE reserved/flag bits, upper VA bits.
  logic unused_bits;
  assign unused_bits = ^{bus_resptag, pte_q[BUS_DATA_WIDTH-1:54], pte_q[9:4],
                         req_vaddr[63:VA_WIDTH], cur_pte_addr[PA_WIDTH-1:OFF_W],
                         cur_pte_addr[2:0]};

endmodule

// File: tb/tb_sv_page_walker.sv
// Directed testbench for sv_page_walker: walks, TLB hits, superpages, faults,
// flush during a walk, reset mid-walk with burst drain, and bare passthrough.
module tb_sv_page_walker;

  logic        clk = 1'b0;
  logic        reset;
  logic        translate_en;
  logic [43:0] ptbr_ppn;
  logic        tlb_flush;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_vaddr;
  logic        resp_valid;
  logic [55:0] resp_paddr;
  logic        resp_fault;
  logic        bus_reqcyc;
  logic [63:0] bus_req;
  logic [12:0] bus_reqtag;
  logic        bus_reqack;
  logic        bus_respcyc;
  logic        bus_respack;
  logic [63:0] bus_resp;
  logic [12:0] bus_resptag;

  sv_page_walker dut (
    .clk(clk), .reset(reset), .translate_en(translate_en), .ptbr_ppn(ptbr_ppn),
    .tlb_flush(tlb_flush), .req_valid(req_valid), .req_ready(req_ready),
    .req_vaddr(req_vaddr), .resp_valid(resp_valid), .resp_paddr(resp_paddr),
    .resp_fault(resp_fault), .bus_reqcyc(bus_reqcyc), .bus_req(bus_req),
    .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc),
    .bus_respack(bus_respack), .bus_resp(bus_resp), .bus_resptag(bus_resptag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mem [logic [55:0]];
  logic [63:0] lines [$];

  int          bursts, lat, acks, wcyc;
  logic [55:0] pa;
  logic        flt, seen;
  logic [63:0] line;
  logic [63:0] exp_lines [4];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mem_rd(input logic [55:0] a);
    return mem.exists(a) ? mem[a] : 64'h0;
  endfunction

  // Present a request from a negedge and wait (bounded) until it has been accepted.
  task automatic issue(input logic [63:0] va, input logic en, input logic [43:0] ptbr);
    int w;
    req_vaddr = va; translate_en = en; ptbr_ppn = ptbr; req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    check("req_ready", req_ready, 1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    // Late changes must not disturb the in-flight translation.
    translate_en = ~en; ptbr_ppn = 44'hABC;
  endtask

  // One full translation: serves every burst from mem and returns the response.
  task automatic run_txn(input logic [63:0] va, input logic en, input logic [43:0] ptbr,
                         output int nb, output logic [55:0] rpa, output logic rflt,
                         output int rlat);
    logic done;
    logic [63:0] ln;
    int nack;
    nb = 0; rpa = '0; rflt = 1'b0; done = 1'b0;
    lines.delete();
    issue(va, en, ptbr);
    rlat = 1;
    while (!done && rlat < 400) begin
      if (resp_valid) begin
        done = 1'b1; rpa = resp_paddr; rflt = resp_fault;
      end else if (bus_reqcyc) begin
        ln = bus_req; lines.push_back(ln); nb++;
        check("bus_reqtag", bus_reqtag, 13'h1100);
        bus_reqack = 1'b1;
        @(negedge clk); rlat++;
        bus_reqack = 1'b0;
        nack = 0;
        for (int i = 0; i < 8; i++) begin
          bus_respcyc = 1'b1;
          bus_resp    = mem_rd(ln[55:0] + 56'(8 * i));
          #1;
          if (bus_respack) nack++;
          @(negedge clk); rlat++;
        end
        bus_respcyc = 1'b0; bus_resp = '0;
        check("beats_acked", nack, 8);
      end else begin
        @(negedge clk); rlat++;
      end
    end
    check("resp_seen", done, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; translate_en = 1'b0; ptbr_ppn = '0; tlb_flush = 1'b0;
    req_valid = 1'b0; req_vaddr = '0; bus_reqack = 1'b0; bus_respcyc = 1'b0;
    bus_resp = '0; bus_resptag = '0;

    mem[56'h100000] = (64'h101 << 10) | 64'h1;
    mem[56'h101000] = (64'h102 << 10) | 64'h1;
    mem[56'h102010] = (64'h103 << 10) | 64'h1;
    mem[56'h103010] = (64'h80000 << 10) | 64'hB;

    repeat (3) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b0);
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_resp_paddr", resp_paddr, 56'h0);
    check("rst_resp_fault", resp_fault, 1'b0);
    check("rst_bus_reqcyc", bus_reqcyc, 1'b0);
    check("rst_bus_req", bus_req, 64'h0);
    check("rst_bus_reqtag", bus_reqtag, 13'h0);
    reset = 1'b0;
    @(negedge clk);

    // Full 4-level walk with 4 KiB pages.
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    exp_lines[0] = 64'h100000; exp_lines[1] = 64'h101000;
    exp_lines[2] = 64'h102000; exp_lines[3] = 64'h103000;
    check("walk_bursts", bursts, 4);
    for (int k = 0; k < 4; k++)
      check("walk_line", (k < lines.size()) ? lines[k] : 64'hDEAD, exp_lines[k]);
    check("walk_paddr", pa, 56'h80000010);
    check("walk_fault", flt, 1'b0);

    // Same page again: TLB hit, one cycle, no bus traffic.
    run_txn(64'h402FF0, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("hit_bursts", bursts, 0);
    check("hit_latency", lat, 1);
    check("hit_paddr", pa, 56'h80000FF0);
    check("hit_fault", flt, 1'b0);
    @(negedge clk);
    check("resp_one_cycle", resp_valid, 1'b0);
    check("ready_after_resp", req_ready, 1'b1);

    // Bare passthrough.
    run_txn(64'h1234, 1'b0, 44'h100, bursts, pa, flt, lat);
    check("bare_bursts", bursts, 0);
    check("bare_latency", lat, 1);
    check("bare_paddr", pa, 56'h1234);
    check("bare_fault", flt, 1'b0);

    // 2 MiB superpage leaf at level 1.
    @(negedge clk); tlb_flush = 1'b1; @(negedge clk); tlb_flush = 1'b0;
    mem[56'h102010] = (64'h80200 << 10) | 64'hB;
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("super_bursts", bursts, 3);
    check("super_paddr", pa, 56'h80202010);
    check("super_fault", flt, 1'b0);
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("super_hit_bursts", bursts, 0);
    check("super_hit_paddr", pa, 56'h80202010);
    run_txn(64'h5FF008, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("super_hit2_bursts", bursts, 0);
    check("super_hit2_paddr", pa, 56'h803FF008);

    // Misaligned superpage faults and is never cached.
    @(negedge clk); tlb_flush = 1'b1; @(negedge clk); tlb_flush = 1'b0;
    mem[56'h102010] = (64'h80201 << 10) | 64'hB;
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("misal_bursts", bursts, 3);
    check("misal_fault", flt, 1'b1);
    check("misal_paddr", pa, 56'h0);
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("misal_refetch_bursts", bursts, 3);
    check("misal_refetch_fault", flt, 1'b1);

    // Invalid root PTE: fault after a single burst.
    run_txn(64'h402010, 1'b1, 44'h200, bursts, pa, flt, lat);
    check("inval_bursts", bursts, 1);
    check("inval_line", (lines.size() > 0) ? lines[0] : 64'hDEAD, 64'h200000);
    check("inval_fault", flt, 1'b1);
    check("inval_paddr", pa, 56'h0);

    // Non-leaf PTE at level 0.
    mem[56'h102010] = (64'h103 << 10) | 64'h1;
    mem[56'h103010] = (64'h104 << 10) | 64'h1;
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("l0_nonleaf_bursts", bursts, 4);
    check("l0_nonleaf_fault", flt, 1'b1);
    mem[56'h103010] = (64'h80000 << 10) | 64'hB;

    // Flush during a walk: result returned, no fill.
    fork
      begin
        repeat (4) @(negedge clk);
        tlb_flush = 1'b1;
        @(negedge clk);
        tlb_flush = 1'b0;
      end
    join_none
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("flushwalk_bursts", bursts, 4);
    check("flushwalk_paddr", pa, 56'h80000010);
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("flushwalk_again_bursts", bursts, 4);
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("flushwalk_filled_bursts", bursts, 0);
    check("flushwalk_filled_paddr", pa, 56'h80000010);

    // Reset while a bus request is pending.
    @(negedge clk); tlb_flush = 1'b1; @(negedge clk); tlb_flush = 1'b0;
    issue(64'h402010, 1'b1, 44'h100);
    check("rstreq_reqcyc_before", bus_reqcyc, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check("rstreq_reqcyc_after", bus_reqcyc, 1'b0);
    check("rstreq_resp_valid", resp_valid, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Reset after 3 beats; the remaining 5 are drained.
    issue(64'h402010, 1'b1, 44'h100);
    wcyc = 0;
    while (!bus_reqcyc && wcyc < 20) begin @(negedge clk); wcyc++; end
    check("rstbeat_reqcyc", bus_reqcyc, 1'b1);
    line = bus_req;
    bus_reqack = 1'b1; @(negedge clk); bus_reqack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus_respcyc = 1'b1; bus_resp = mem_rd(line[55:0] + 56'(8 * i));
      @(negedge clk);
    end
    reset = 1'b1;
    acks = 0; seen = 1'b0;
    for (int i = 3; i < 8; i++) begin
      bus_respcyc = 1'b1; bus_resp = mem_rd(line[55:0] + 56'(8 * i));
      #1;
      if (bus_respack) acks++;
      @(negedge clk);
      reset = 1'b0;
      if (resp_valid || bus_reqcyc) seen = 1'b1;
    end
    bus_respcyc = 1'b0; bus_resp = '0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || bus_reqcyc) seen = 1'b1;
    end
    check("drain_acks", acks, 5);
    check("drain_no_activity", seen, 1'b0);
    run_txn(64'h402010, 1'b1, 44'h100, bursts, pa, flt, lat);
    check("post_rst_bursts", bursts, 4);
    check("post_rst_paddr", pa, 56'h80000010);
    check("post_rst_fault", flt, 1'b0);

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sv_page_walker.md
Name: sv_page_walker

Overview:
- Parametrised instruction-side address translator between the fetch stage and the Sysbus.
- Holds a small fully-associative TLB. On a miss it performs an Sv39/Sv48-style multi-level page-table walk, issuing one cache-line burst read per level and extracting the PTE from the correct beat.
- Returns a physical address or a page fault to fetch, with one translation outstanding at a time.
- Bare mode passes addresses through.

Parameters:
- BUS_DATA_WIDTH, 64, Sysbus data width; one beat = one PTE.
- BUS_TAG_WIDTH, 13, Sysbus tag width.
- LEVELS, 4, page-table levels (3=Sv39, 4=Sv48); VA_WIDTH = 12+9*LEVELS.
- PA_WIDTH, 56, physical address width.
- LINE_BEATS, 8, beats per burst (64-byte line); power of two.
- PTESIZE, 8, bytes per PTE.
- TLB_ENTRIES, 4, TLB entries (>=1).

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- translate_en  input  1  1=paged mode, 0=bare passthrough.
- ptbr_ppn  input  44  root page-table PPN; root address = ptbr_ppn<<12.
- tlb_flush  input  1  invalidate all TLB entries.
- req_valid  input  1  translation request.
- req_ready  output  1  high only in IDLE.
- req_vaddr  input  64  virtual fetch address.
- resp_valid  output  1  one-cycle result pulse.
- resp_paddr  output  PA_WIDTH  translated address (0 when faulted).
- resp_fault  output  1  page fault, qualified by resp_valid.
- bus_reqcyc  output  1  bus request valid.
- bus_req  output  BUS_DATA_WIDTH  line-aligned PTE line address.
- bus_reqtag  output  BUS_TAG_WIDTH  constant SYSBUS_READ<<12 | SYSBUS_MEMORY<<8.
- bus_reqack  input  1  request accepted.
- bus_respcyc  input  1  response beat valid.
- bus_respack  output  1  beat consumed.
- bus_resp  input  BUS_DATA_WIDTH  response beat data.
- bus_resptag  input  BUS_TAG_WIDTH  response tag (ignored).

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - All TLB valid bits 0.
  - Replacement pointer 0.
- Handshake: a request is accepted when req_valid && req_ready (sampled on cycle N). req_vaddr is latched at that edge.
- Bare mode (translate_en=0 at accept):
  - resp_valid=1 at N+1, resp_paddr = vaddr[PA_WIDTH-1:0], fault=0.
  - The TLB is not consulted.
- TLB lookup:
  - Tag = vaddr[VA_WIDTH-1:12]. An entry stores {valid, vpn, ppn, level}.
  - Match on vpn bits above 9*level.
  - Hit: resp_valid at N+1, paddr formed as below.
  - Miss: go to REQ with lvl=LEVELS-1 and a = ptbr_ppn<<12.
- States:
  - IDLE: accepts requests; drives req_ready=1.
  - REQ: pte_addr = a + vpn[lvl]*PTESIZE. Drive bus_reqcyc=1 and bus_req = pte_addr with the low log2(LINE_BEATS*8) bits cleared. Hold both until bus_reqack is sampled high, then go to BEATS with beat counter = 0.
  - BEATS:
    - bus_respack = bus_respcyc, combinational.
    - Each acked beat increments the counter.
    - The beat whose index equals pte_addr[log2(LINE_BEATS*8)-1:3] is captured as pte.
    - After LINE_BEATS beats, go to CHECK.
  - CHECK (one cycle), PTE decoding: V=pte[0], R=pte[1], W=pte[2], X=pte[3], ppn = pte[53:10].
    - Fault if !V, or (W && !R).
    - Non-leaf (!R && !X): if lvl==0, fault; else a = ppn<<12, lvl-1, go to REQ.
    - Leaf, fault if X=0 or ppn[9*lvl-1:0] != 0 (misaligned superpage).
    - Leaf, success: fill the TLB entry at the pointer, unless a flush happened during the walk. Advance the pointer modulo TLB_ENTRIES.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Physical address: paddr = (ppn<<12) with bits [12+9*lvl-1:0] replaced by vaddr bits, truncated to PA_WIDTH.
- Faults are never cached in the TLB. On a fault, resp_paddr=0.
- tlb_flush:
  - In IDLE: clears all valid bits next edge. A flush in the same cycle as a request acceptance forces that lookup to miss.
  - During a walk: the walk completes and the result is returned, but no fill is made.
- Burst drain: a response beat arriving outside BEATS (e.g. a stray burst after reset) is acked with bus_respack=1 and discarded, so the bus never stalls.
- Reset mid-walk: bus_reqcyc drops next edge, state returns to IDLE, no resp_valid is issued.
- translate_en and ptbr_ppn are sampled only at accept; later changes do not affect an in-flight walk.

Test Plan:
- Sv48 4-level walk, ptbr_ppn=0x100, vaddr=0x402010, PTEs all 4KiB:
  - 0x100000 beat0 -> ppn 0x101.
  - 0x101000 beat0 -> ppn 0x102.
  - 0x102010 beat2 -> ppn 0x103.
  - 0x103010 beat2 leaf ppn 0x80000 with V|R|X.
  - Required: bus_req sequence 0x100000, 0x101000, 0x102000, 0x103000; resp_paddr=0x80000010, fault=0.
- Repeat vaddr=0x402FF0 after the walk above -> no bus_reqcyc, resp_valid one cycle after accept, paddr=0x80000FF0.
- 2MiB superpage: level-1 PTE at 0x102010 is a leaf with ppn 0x80200 -> paddr=0x80202010. Same test with ppn 0x80201 -> resp_fault=1, paddr=0, no TLB fill.
- Invalid PTE (V=0) at the root -> fault after exactly one burst. Non-leaf at level 0 -> fault.
- tlb_flush asserted during a walk, then the same vaddr repeated -> second request walks again (4 bursts).
- Reset asserted in BEATS after 3 beats -> remaining 5 beats acked and discarded; next request completes normally. Bare mode vaddr=0x1234 -> paddr=0x1234 at N+1.
